// File: rtl/pc_block_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_block_serializer_if
//  Description : Bundle of the encoder-side block input and the downstream
//                valid/ready word stream of the product-code serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_block_serializer_if #(
    parameter int N = 256
);
    // Encoder side: one pulse presents all sixteen row codewords.
    logic         new1;
    logic [N-1:0] in_codeword1;
    logic [N-1:0] in_codeword2;
    logic [N-1:0] in_codeword3;
    logic [N-1:0] in_codeword4;
    logic [N-1:0] in_codeword5;
    logic [N-1:0] in_codeword6;
    logic [N-1:0] in_codeword7;
    logic [N-1:0] in_codeword8;
    logic [N-1:0] in_codeword9;
    logic [N-1:0] in_codeword10;
    logic [N-1:0] in_codeword11;
    logic [N-1:0] in_codeword12;
    logic [N-1:0] in_codeword13;
    logic [N-1:0] in_codeword14;
    logic [N-1:0] in_codeword15;
    logic [N-1:0] in_codeword16;
    logic         hold_enc;
    logic         overflow;
    // Downstream stream side.
    logic [63:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    // Block producer / stream consumer view.
    modport master (
        output new1,
        output in_codeword1, in_codeword2, in_codeword3, in_codeword4,
        output in_codeword5, in_codeword6, in_codeword7, in_codeword8,
        output in_codeword9, in_codeword10, in_codeword11, in_codeword12,
        output in_codeword13, in_codeword14, in_codeword15, in_codeword16,
        output m_ready,
        input  hold_enc, overflow, m_data, m_valid, m_last
    );

    // Serializer view.
    modport slave (
        input  new1,
        input  in_codeword1, in_codeword2, in_codeword3, in_codeword4,
        input  in_codeword5, in_codeword6, in_codeword7, in_codeword8,
        input  in_codeword9, in_codeword10, in_codeword11, in_codeword12,
        input  in_codeword13, in_codeword14, in_codeword15, in_codeword16,
        input  m_ready,
        output hold_enc, overflow, m_data, m_valid, m_last
    );
endinterface
`default_nettype wire

// File: rtl/pc_block_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_block_serializer
//  Description : Double-buffered column interleaver. Captures sixteen row
//                codewords per block and streams them out one nibble column
//                (64 bits) per transfer, staging a second block meanwhile.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_block_serializer #(
    parameter int N    = 256,
    parameter int ROWS = 16
) (
    input  wire                   clk,
    input  wire                   reset,
    pc_block_serializer_if.slave  bus
);

    localparam int              c_WORDS = N / 4;
    localparam int              c_CW    = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_WORDS - 1);

    // Buffer occupancy: STREAM = ACTIVE only, FULL = ACTIVE and PENDING.
    localparam logic [1:0] c_S_EMPTY  = 2'd0;
    localparam logic [1:0] c_S_STREAM = 2'd1;
    localparam logic [1:0] c_S_FULL   = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [N-1:0]        r_act  [ROWS];
    logic [N-1:0]        r_pend [ROWS];
    logic [N-1:0]        w_in   [ROWS];
    logic [c_CW-1:0]     r_cnt;
    logic                r_hold;
    logic                r_ovf;
    logic                w_valid;
    logic                w_xfer;
    logic                w_last_xfer;
    logic                w_ld_act_in;
    logic                w_ld_act_pend;
    logic                w_ld_pend;
    logic                w_drop;
    logic [4*ROWS-1:0]   w_data;

    // Gather the individually named row inputs into an indexable array.
    always_comb begin
        w_in[0]  = bus.in_codeword1;
        w_in[1]  = bus.in_codeword2;
        w_in[2]  = bus.in_codeword3;
        w_in[3]  = bus.in_codeword4;
        w_in[4]  = bus.in_codeword5;
        w_in[5]  = bus.in_codeword6;
        w_in[6]  = bus.in_codeword7;
        w_in[7]  = bus.in_codeword8;
        w_in[8]  = bus.in_codeword9;
        w_in[9]  = bus.in_codeword10;
        w_in[10] = bus.in_codeword11;
        w_in[11] = bus.in_codeword12;
        w_in[12] = bus.in_codeword13;
        w_in[13] = bus.in_codeword14;
        w_in[14] = bus.in_codeword15;
        w_in[15] = bus.in_codeword16;
    end

    assign w_valid     = (r_state != c_S_EMPTY);
    assign w_xfer      = w_valid && bus.m_ready;
    assign w_last_xfer = w_xfer && (r_cnt == c_LAST);

    // Column k of the ACTIVE block: nibble k of every row, row r in nibble r.
    always_comb begin
        w_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_data[4*r +: 4] = r_act[r][{r_cnt, 2'b00} +: 4];
        end
    end

    assign bus.m_data   = w_data;
    assign bus.m_valid  = w_valid;
    assign bus.m_last   = w_valid && (r_cnt == c_LAST);
    assign bus.hold_enc = r_hold;
    assign bus.overflow = r_ovf;

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy and buffer-move decisions. A final-word transfer frees
    // ACTIVE in the same cycle, so a coinciding pulse never sees a full pair.
    always_comb begin
        w_state_nxt   = r_state;
        w_ld_act_in   = 1'b0;
        w_ld_act_pend = 1'b0;
        w_ld_pend     = 1'b0;
        w_drop        = 1'b0;
        case (r_state)
            c_S_EMPTY: begin
                if (bus.new1) begin
                    w_ld_act_in = 1'b1;
                    w_state_nxt = c_S_STREAM;
                end
            end
            c_S_STREAM: begin
                if (w_last_xfer) begin
                    if (bus.new1) begin
                        w_ld_act_in = 1'b1;
                    end else begin
                        w_state_nxt = c_S_EMPTY;
                    end
                end else if (bus.new1) begin
                    w_ld_pend   = 1'b1;
                    w_state_nxt = c_S_FULL;
                end
            end
            c_S_FULL: begin
                if (w_last_xfer) begin
                    w_ld_act_pend = 1'b1;
                    if (bus.new1) begin
                        w_ld_pend = 1'b1;
                    end else begin
                        w_state_nxt = c_S_STREAM;
                    end
                end else if (bus.new1) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_EMPTY;
            end
        endcase
    end

    // Block buffers: ACTIVE loads from the input or from PENDING.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                r_act[r]  <= '0;
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (w_ld_act_in) begin
                    r_act[r] <= w_in[r];
                end else if (w_ld_act_pend) begin
                    r_act[r] <= r_pend[r];
                end
                if (w_ld_pend) begin
                    r_pend[r] <= w_in[r];
                end
            end
        end
    end

    // Word counter, encoder hold flag and sticky drop flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_hold <= 1'b1;
            r_ovf  <= 1'b0;
        end else begin
            if (w_last_xfer) begin
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_hold <= (w_state_nxt != c_S_FULL);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
